// File: rtl/spi_ctrl_pkg.sv
// Shared definitions for the SPI register controller: state encoding, command
// fields and status byte layout.
package spi_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WRITE     = 3'd1,
        ST_READ_REQ  = 3'd2,
        ST_READ_WAIT = 3'd3,
        ST_READ_HOLD = 3'd4
    } state_t;

    localparam int         CMD_READ_BIT     = 7;
    localparam logic [6:0] ERROR_CLEAR_ADDR = 7'h7F;
    localparam int         STATUS_ERROR_BIT = 7;
    localparam int         STATUS_BUSY_BIT  = 0;

    function automatic logic [7:0] status_byte(input logic err, input logic busy);
        logic [7:0] s;
        s = 8'h00;
        s[STATUS_ERROR_BIT] = err;
        s[STATUS_BUSY_BIT]  = busy;
        return s;
    endfunction

endpackage

// File: rtl/spi_read_timer.sv
// Read-response timer: cleared by load, counts while enabled, saturates and
// flags expiry once READ_TIMEOUT cycles have elapsed.
module spi_read_timer
    import spi_ctrl_pkg::*;
#(
    parameter int READ_TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic enable,
    output logic expired
);

    localparam int            CW    = $clog2(READ_TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(READ_TIMEOUT);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || load) begin
            count <= '0;
        end else if (enable && count != LIMIT) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == LIMIT);

endmodule

// File: rtl/spi_register_controller.sv
// Byte-level command sequencer from the SPI device byte stream to an 8-bit
// register bus. Optional status byte on IDLE entry: SPI_REGISTER_CONTROLLER_STATUS_EN.
module spi_register_controller
    import spi_ctrl_pkg::*;
#(
    parameter int         READ_TIMEOUT = 16,
    parameter logic [7:0] FILL_BYTE    = 8'hFF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_active,
    input  logic [7:0] rx_data,
    input  logic       rx_strobe,
    output logic [7:0] tx_data,
    output logic       tx_strobe,
    output logic [6:0] reg_addr,
    output logic [7:0] reg_wr_data,
    output logic       reg_wr_strobe,
    output logic       reg_rd_strobe,
    input  logic [7:0] reg_rd_data,
    input  logic       reg_rd_valid,
    output logic       error
);

    state_t state;
    logic   wr_pulse;
    logic   rd_pulse;
    logic   timer_expired;
`ifdef SPI_REGISTER_CONTROLLER_STATUS_EN
    logic   status_pending;
    logic   busy;
`endif

    spi_read_timer #(.READ_TIMEOUT(READ_TIMEOUT)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .load    (state == ST_READ_REQ),
        .enable  (state == ST_READ_WAIT),
        .expired (timer_expired)
    );

    // Register strobes are masked in the reset cycle itself, not one cycle later.
    assign reg_wr_strobe = wr_pulse & ~reset;
    assign reg_rd_strobe = rd_pulse & ~reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            reg_addr    <= '0;
            reg_wr_data <= '0;
            wr_pulse    <= 1'b0;
            rd_pulse    <= 1'b0;
            tx_data     <= '0;
            tx_strobe   <= 1'b0;
            error       <= 1'b0;
`ifdef SPI_REGISTER_CONTROLLER_STATUS_EN
            status_pending <= 1'b1;
            busy           <= 1'b0;
`endif
        end else begin
            wr_pulse  <= 1'b0;
            rd_pulse  <= 1'b0;
            tx_strobe <= 1'b0;
            if (wr_pulse) begin
                reg_addr <= reg_addr + 7'd1;
            end
            // A write byte arriving as the frame closes still completes.
            if (state == ST_WRITE && rx_strobe) begin
                reg_wr_data <= rx_data;
                wr_pulse    <= 1'b1;
                if (reg_addr == ERROR_CLEAR_ADDR) begin
                    error <= 1'b0;
                end
            end
`ifdef SPI_REGISTER_CONTROLLER_STATUS_EN
            if (state == ST_IDLE && status_pending) begin
                tx_strobe      <= 1'b1;
                tx_data        <= status_byte(error, busy);
                status_pending <= 1'b0;
            end
`endif
            if (!frame_active) begin
                state <= ST_IDLE;
`ifdef SPI_REGISTER_CONTROLLER_STATUS_EN
                if (state != ST_IDLE) begin
                    status_pending <= 1'b1;
                    busy           <= (state == ST_READ_WAIT);
                end
`endif
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (rx_strobe) begin
                            reg_addr <= rx_data[6:0];
                            state    <= rx_data[CMD_READ_BIT] ? ST_READ_REQ : ST_WRITE;
                        end
                    end
                    ST_WRITE: begin
                    end
                    ST_READ_REQ: begin
                        rd_pulse <= 1'b1;
                        state    <= ST_READ_WAIT;
                        if (rx_strobe) begin
                            reg_addr <= reg_addr + 7'd1;
                            error    <= 1'b1;
                        end
                    end
                    ST_READ_WAIT: begin
                        // Host outran the register bus: consume the byte, flag it.
                        if (rx_strobe) begin
                            reg_addr <= reg_addr + 7'd1;
                            error    <= 1'b1;
                        end
                        if (reg_rd_valid) begin
                            tx_data   <= reg_rd_data;
                            tx_strobe <= 1'b1;
                            state     <= ST_READ_HOLD;
                        end else if (timer_expired) begin
                            tx_data   <= FILL_BYTE;
                            tx_strobe <= 1'b1;
                            error     <= 1'b1;
                            state     <= ST_READ_HOLD;
                        end
                    end
                    ST_READ_HOLD: begin
                        if (rx_strobe) begin
                            reg_addr <= reg_addr + 7'd1;
                            state    <= ST_READ_REQ;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_register_controller.sv
// Directed bench for spi_register_controller: write/read bursts, timeout,
// error clear, address wrap, frame abort and mid-frame reset.
module tb_spi_register_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       frame_active = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_strobe = 1'b0;
    logic [7:0] tx_data;
    logic       tx_strobe;
    logic [6:0] reg_addr;
    logic [7:0] reg_wr_data;
    logic       reg_wr_strobe;
    logic       reg_rd_strobe;
    logic [7:0] reg_rd_data = 8'h00;
    logic       reg_rd_valid = 1'b0;
    logic       error;

    spi_register_controller dut (
        .clk           (clk),
        .reset         (reset),
        .frame_active  (frame_active),
        .rx_data       (rx_data),
        .rx_strobe     (rx_strobe),
        .tx_data       (tx_data),
        .tx_strobe     (tx_strobe),
        .reg_addr      (reg_addr),
        .reg_wr_data   (reg_wr_data),
        .reg_wr_strobe (reg_wr_strobe),
        .reg_rd_strobe (reg_rd_strobe),
        .reg_rd_data   (reg_rd_data),
        .reg_rd_valid  (reg_rd_valid),
        .error         (error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_rx_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Bus and tx observation log, sampled mid-cycle.
    int         n_wr = 0, n_rd = 0, n_tx = 0, n_consec = 0;
    logic [6:0] wr_addr_log [0:63];
    logic [7:0] wr_data_log [0:63];
    int         rd_cyc_log  [0:63];
    logic [7:0] tx_log      [0:63];
    int         tx_cyc_log  [0:63];
    logic       prev_tx = 1'b0, prev_wr = 1'b0, prev_rd = 1'b0;

    always @(negedge clk) begin
        if (reg_wr_strobe) begin
            wr_addr_log[6'(n_wr)] <= reg_addr;
            wr_data_log[6'(n_wr)] <= reg_wr_data;
            n_wr <= n_wr + 1;
        end
        if (reg_rd_strobe) begin
            rd_cyc_log[6'(n_rd)] <= cyc;
            n_rd <= n_rd + 1;
        end
        if (tx_strobe) begin
            tx_log[6'(n_tx)]     <= tx_data;
            tx_cyc_log[6'(n_tx)] <= cyc;
            n_tx <= n_tx + 1;
        end
        if ((tx_strobe && prev_tx) || (reg_wr_strobe && prev_wr) || (reg_rd_strobe && prev_rd))
            n_consec <= n_consec + 1;
        prev_tx <= tx_strobe;
        prev_wr <= reg_wr_strobe;
        prev_rd <= reg_rd_strobe;
    end

    // Register model: answers a read strobe after model_delay cycles.
    bit         model_en = 1'b0;
    int         model_delay = 2;
    int         pend_cnt = 0;
    logic [6:0] pend_addr = 7'h00;

    function automatic logic [7:0] model_mem(input logic [6:0] a);
        case (a)
            7'h10:   return 8'h3C;
            7'h11:   return 8'hC3;
            default: return {1'b0, a};
        endcase
    endfunction

    always @(negedge clk) begin
        reg_rd_valid <= 1'b0;
        if (pend_cnt != 0) begin
            pend_cnt <= pend_cnt - 1;
            if (pend_cnt == 1) begin
                reg_rd_valid <= 1'b1;
                reg_rd_data  <= model_mem(pend_addr);
            end
        end
        if (model_en && reg_rd_strobe) begin
            pend_cnt  <= model_delay;
            pend_addr <= reg_addr;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_data     = b;
        rx_strobe   = 1'b1;
        last_rx_cyc = cyc;
        tick(1);
        rx_strobe = 1'b0;
        if (gap > 0) tick(gap);
    endtask

    task automatic wait_tx(input int base, input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (n_tx > base) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int w0, r0, t0, cmd_cyc;
        bit ok;

        // Reset state
        tick(3);
        check("rst_addr", 32'(reg_addr), 32'h0);
        check("rst_error", 32'(error), 32'h0);
        check("rst_tx", 32'({tx_strobe, tx_data}), 32'h0);
        check("rst_bus", 32'({reg_wr_strobe, reg_rd_strobe, reg_wr_data}), 32'h0);
        reset = 1'b0;
        tick(4);

        // Write burst 05 AA 55
        frame_active = 1'b1;
        tick(2);
        w0 = n_wr; r0 = n_rd; t0 = n_tx;
        send_byte(8'h05, 4);
        send_byte(8'hAA, 4);
        send_byte(8'h55, 4);
        check("wr_count", 32'(n_wr - w0), 32'd2);
        check("wr0", 32'({wr_addr_log[6'(w0)], wr_data_log[6'(w0)]}), 32'({7'h05, 8'hAA}));
        check("wr1", 32'({wr_addr_log[6'(w0 + 1)], wr_data_log[6'(w0 + 1)]}), 32'({7'h06, 8'h55}));
        check("wr_no_rd", 32'(n_rd - r0), 32'd0);
        check("wr_addr_after", 32'(reg_addr), 32'h07);
        check("wr_no_tx", 32'(n_tx - t0), 32'd0);
        frame_active = 1'b0;
        tick(4);

        // Read burst from 0x10 with a 2-cycle register model
        model_en = 1'b1;
        model_delay = 2;
        frame_active = 1'b1;
        tick(2);
        r0 = n_rd; t0 = n_tx;
        send_byte(8'h90, 0);
        cmd_cyc = last_rx_cyc;
        tick(10);
        send_byte(8'h00, 10);
        send_byte(8'h00, 0);
        check("rd_addr_after", 32'(reg_addr), 32'h12);
        frame_active = 1'b0;
        tick(6);
        check("rd_count", 32'(n_rd - r0), 32'd2);
        check("rd_latency", 32'(rd_cyc_log[6'(r0)] - cmd_cyc), 32'd2);
        check("rd_valid_to_tx", 32'(tx_cyc_log[6'(t0)] - rd_cyc_log[6'(r0)]), 32'd3);
        check("rd_tx0", 32'(tx_log[6'(t0)]), 32'h3C);
        check("rd_tx1", 32'(tx_log[6'(t0 + 1)]), 32'hC3);
`ifdef SPI_REGISTER_CONTROLLER_STATUS_EN
        check("rd_tx_count", 32'(n_tx - t0), 32'd3);
        check("rd_status", 32'(tx_log[6'(t0 + 2)]), 32'h00);
`else
        check("rd_tx_count", 32'(n_tx - t0), 32'd2);
`endif
        model_en = 1'b0;

        // Read timeout
        frame_active = 1'b1;
        tick(2);
        r0 = n_rd; t0 = n_tx;
        check("to_error_before", 32'(error), 32'h0);
        send_byte(8'h81, 0);
        wait_tx(t0, 40, ok);
        check("to_tx_seen", 32'(ok), 32'h1);
        check("to_fill", 32'(tx_log[6'(t0)]), 32'hFF);
        check("to_wait", 32'(tx_cyc_log[6'(t0)] - rd_cyc_log[6'(r0)]), 32'd17);
        check("to_error", 32'(error), 32'h1);
        frame_active = 1'b0;
        tick(4);
`ifdef SPI_REGISTER_CONTROLLER_STATUS_EN
        check("to_status", 32'(tx_log[6'(t0 + 1)]), 32'h80);
`endif

        // Write to 0x7F clears error
        frame_active = 1'b1;
        tick(2);
        w0 = n_wr;
        send_byte(8'h7F, 4);
        send_byte(8'h00, 4);
        check("clr_write", 32'({wr_addr_log[6'(w0)], wr_data_log[6'(w0)]}), 32'({7'h7F, 8'h00}));
        check("clr_error", 32'(error), 32'h0);
        frame_active = 1'b0;
        tick(4);

        // Abort during READ_WAIT; late valid must be ignored
        model_en = 1'b1;
        model_delay = 8;
        frame_active = 1'b1;
        tick(2);
        r0 = n_rd; t0 = n_tx;
        send_byte(8'h82, 4);
        frame_active = 1'b0;
        tick(15);
        check("ab_rd_count", 32'(n_rd - r0), 32'd1);
`ifdef SPI_REGISTER_CONTROLLER_STATUS_EN
        check("ab_tx_count", 32'(n_tx - t0), 32'd1);
        check("ab_status", 32'(tx_log[6'(t0)]), 32'h01);
`else
        check("ab_tx_count", 32'(n_tx - t0), 32'd0);
`endif
        model_en = 1'b0;
        frame_active = 1'b1;
        tick(2);
        w0 = n_wr;
        send_byte(8'h03, 4);
        send_byte(8'h44, 4);
        check("ab_next_cmd", 32'({wr_addr_log[6'(w0)], wr_data_log[6'(w0)]}), 32'({7'h03, 8'h44}));
        frame_active = 1'b0;
        tick(4);

        // Address wrap 7E -> 7F -> 00
        frame_active = 1'b1;
        tick(2);
        w0 = n_wr;
        send_byte(8'h7E, 4);
        send_byte(8'h01, 4);
        send_byte(8'h02, 4);
        send_byte(8'h03, 4);
        check("wrap_count", 32'(n_wr - w0), 32'd3);
        check("wrap0", 32'({wr_addr_log[6'(w0)], wr_data_log[6'(w0)]}), 32'({7'h7E, 8'h01}));
        check("wrap1", 32'({wr_addr_log[6'(w0 + 1)], wr_data_log[6'(w0 + 1)]}), 32'({7'h7F, 8'h02}));
        check("wrap2", 32'({wr_addr_log[6'(w0 + 2)], wr_data_log[6'(w0 + 2)]}), 32'({7'h00, 8'h03}));
        frame_active = 1'b0;
        tick(4);

        // Reset in the very cycle a write strobe is out
        frame_active = 1'b1;
        tick(2);
        send_byte(8'h10, 4);
        rx_data   = 8'h99;
        rx_strobe = 1'b1;
        tick(1);
        rx_strobe = 1'b0;
        reset     = 1'b1;
        #1;
        check("rst_mid_wr_masked", 32'(reg_wr_strobe), 32'h0);
        tick(1);
        check("rst_mid_addr", 32'(reg_addr), 32'h0);
        check("rst_mid_data", 32'(reg_wr_data), 32'h0);
        reset = 1'b0;
        frame_active = 1'b0;
        tick(4);

        check("no_consecutive_strobes", 32'(n_consec), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
